a_seq_tx: RTL



---
 rtl/a_seq_tx_if.sv | 25 ++
 rtl/a_seq_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/a_seq_tx_if.sv
// Command, line and status bundle between a command source and a_seq_tx.
// The slave modport is the transmitter's view of the bundle; the master modport is the command source's view.
interface a_seq_tx_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_cnt_i;
    logic       A_o;
    logic       K1_i;
    logic       K2_i;
    logic       busy_o;
    logic       done_o;
    logic       k2_miss_o;
    logic       k1_tmo_o;
    logic [7:0] ok_cnt_o;

    modport slave (
        input  cmd_valid_i, cmd_cnt_i, K1_i, K2_i,
        output cmd_ready_o, A_o, busy_o, done_o, k2_miss_o, k1_tmo_o, ok_cnt_o
    );

    modport master (
        output cmd_valid_i, cmd_cnt_i, K1_i, K2_i,
        input  cmd_ready_o, A_o, busy_o, done_o, k2_miss_o, k1_tmo_o, ok_cnt_o
    );
endinterface

// File: rtl/a_seq_tx.sv
// Frame transmitter for the A/K1/K2 handshake: sends rise-fall-rise-fall frames and checks the responder.
// Define A_SEQ_TX_CHECK_EN to enable K1/K2 checking with a K1 timeout; otherwise frames end in a fixed low phase.
module a_seq_tx #(
    parameter int unsigned HI_CYC  = 2,
    parameter int unsigned LO_CYC  = 2,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned TMO_CYC = 64
) (
    input  logic        clk_i,
    input  logic        rst,
    a_seq_tx_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, H1, L1, H2, WAIT, GAP, DONE} state_t;

`ifdef A_SEQ_TX_CHECK_EN
    localparam logic [7:0] WAIT_LEN = 8'(TMO_CYC);
`else
    localparam logic [7:0] WAIT_LEN = 8'(LO_CYC);
`endif

    state_t     state;
    logic [7:0] phase_cnt;
    logic [7:0] frames_left;
    logic       last_phase;
    logic       wait_exit;
    logic       a_line;
    logic       ready;
    logic       busy;
    logic       done;
    logic       k2_miss;
    logic       k1_tmo;
    logic [7:0] ok_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign last_phase = (phase_cnt == 8'd1);

`ifdef A_SEQ_TX_CHECK_EN
    logic k2_seen;
    logic k2_now;
    // K2 in the exiting WAIT cycle still counts for this frame.
    assign k2_now    = k2_seen | bus.K2_i;
    assign wait_exit = bus.K1_i | last_phase;
`else
    logic unused_k;
    assign unused_k  = bus.K1_i | bus.K2_i;
    assign wait_exit = last_phase;
`endif

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state   <= IDLE;
            a_line  <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            k2_miss <= 1'b0;
            k1_tmo  <= 1'b0;
            ok_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i && ready) begin
                        frames_left <= (bus.cmd_cnt_i == 8'd0) ? 8'd1 : bus.cmd_cnt_i;
                        k2_miss     <= 1'b0;
                        k1_tmo      <= 1'b0;
                        ok_cnt      <= 8'd0;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                        a_line      <= 1'b1;
                        phase_cnt   <= 8'(HI_CYC);
                        state       <= H1;
                    end
                end
                H1: begin
                    if (last_phase) begin
                        a_line    <= 1'b0;
                        phase_cnt <= 8'(LO_CYC);
                        state     <= L1;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                L1: begin
                    if (last_phase) begin
                        a_line    <= 1'b1;
                        phase_cnt <= 8'(HI_CYC);
                        state     <= H2;
`ifdef A_SEQ_TX_CHECK_EN
                        k2_seen   <= 1'b0;
`endif
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                H2: begin
`ifdef A_SEQ_TX_CHECK_EN
                    if (bus.K2_i) k2_seen <= 1'b1;
`endif
                    if (last_phase) begin
                        a_line    <= 1'b0;
                        phase_cnt <= WAIT_LEN;
                        state     <= WAIT;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                WAIT: begin
                    if (wait_exit) begin
`ifdef A_SEQ_TX_CHECK_EN
                        if (!k2_now)              k2_miss <= 1'b1;
                        if (!bus.K1_i)            k1_tmo  <= 1'b1;
                        if (k2_now && bus.K1_i)   ok_cnt  <= sat_inc(ok_cnt);
`else
                        ok_cnt <= sat_inc(ok_cnt);
`endif
                        if (frames_left > 8'd1) begin
                            frames_left <= frames_left - 8'd1;
                            phase_cnt   <= 8'(GAP_CYC);
                            state       <= GAP;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
`ifdef A_SEQ_TX_CHECK_EN
                        if (bus.K2_i) k2_seen <= 1'b1;
`endif
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                GAP: begin
                    if (last_phase) begin
                        a_line    <= 1'b1;
                        phase_cnt <= 8'(HI_CYC);
                        state     <= H1;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.A_o         = a_line;
    assign bus.cmd_ready_o = ready;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.k2_miss_o   = k2_miss;
    assign bus.k1_tmo_o    = k1_tmo;
    assign bus.ok_cnt_o    = ok_cnt;

endmodule
